fifo_rd_ctrl: RTL

//  Read-side pointer/flag controller of the async FIFO, mirroring the write-side controller.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ptr_sync.sv | 29 ++
 rtl/fifo_rd_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width defaults and binary/gray conversion,
// used by both the read and the write pointer controllers.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;

    // Widest pointer the helpers handle; callers zero-extend narrower pointers.
    localparam int PTR_MAX = 16;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros from zero-extension leave the low bits of the result unaffected.
    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
        logic [PTR_MAX-1:0] bin;
        bin[PTR_MAX-1] = gray[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Plain multi-flop bitwise synchronizer for a gray pointer crossing clock domains.
// Shared by the read controller (write pointer in) and the write controller (read pointer in).
module fifo_ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             R_CLK,
    input  logic             R_RST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    // Straight flop chain: nothing combinational between stages.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            stage <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the async FIFO: binary/gray read pointer,
// synchronized write pointer, registered EMPTY / ALMOST_EMPTY / level, and read-valid pulse.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  R_INC,
    input  logic [ADDR_WIDTH:0]   WR_RD_PTR,
    output logic [ADDR_WIDTH-1:0] R_ADDR,
    output logic [ADDR_WIDTH:0]   r_gray_out,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   RD_LEVEL,
    output logic                  R_VALID
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW:0] AE_LIMIT = (PW + 1)'(AEMPTY_THRESH);

    logic [PW-1:0]      r_bin;
    logic [PW-1:0]      r_bin_nxt;
    logic [PW-1:0]      r_gray_nxt;
    logic [PW-1:0]      wq_gray;
    logic [PW-1:0]      wq_bin;
    logic [PW-1:0]      level_nxt;
    logic [PTR_MAX-1:0] gray_wide;
    logic [PTR_MAX-1:0] wq_bin_wide;
    logic               rd_en;

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .R_CLK (R_CLK),
        .R_RST (R_RST),
        .d     (WR_RD_PTR),
        .q     (wq_gray)
    );

    // Flags are computed from the post-read pointer so a draining read raises EMPTY
    // on the same edge that moves the pointer.
    always_comb begin
        rd_en       = R_INC & ~EMPTY;
        r_bin_nxt   = r_bin + PW'(rd_en);
        gray_wide   = bin2gray(PTR_MAX'(r_bin_nxt));
        r_gray_nxt  = gray_wide[PW-1:0];
        wq_bin_wide = gray2bin(PTR_MAX'(wq_gray));
        wq_bin      = wq_bin_wide[PW-1:0];
        level_nxt   = wq_bin - r_bin_nxt;
    end

    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            r_bin        <= '0;
            r_gray_out   <= '0;
            EMPTY        <= 1'b1;
            ALMOST_EMPTY <= 1'b1;
            RD_LEVEL     <= '0;
            R_VALID      <= 1'b0;
        end else begin
            r_bin        <= r_bin_nxt;
            r_gray_out   <= r_gray_nxt;
            EMPTY        <= (r_gray_nxt == wq_gray);
            ALMOST_EMPTY <= ({1'b0, level_nxt} <= AE_LIMIT);
            RD_LEVEL     <= level_nxt;
            R_VALID      <= rd_en;
        end
    end

    assign R_ADDR = r_bin[ADDR_WIDTH-1:0];

endmodule
